instr_fetch: RTL

Instruction fetch unit for the 16-bit processor. It owns the program counter, issues reads to a synchronous instruction memory, and buffers returned words in a small prefetch queue. It presents instructions to the decoder over a valid/ready handshake, replacing testbench-driven instruction injection. It also supports PC redirects for branches and jumps, and stops fetching when the end-of-program word (16'h0000) is consumed.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/instr_fetch_if.sv | 38 +++
 rtl/fetch_fifo.sv | 86 ++++++++
 rtl/instr_fetch.sv | 101 ++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared definitions for the 16-bit processor: word width,
//               end-of-program word, and instruction field positions used by
//               the downstream decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

  // Consuming this word ends the program.
  localparam word_t HALT_WORD = 16'h0000;

  // Instruction field positions.
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;
  localparam int RDEST_MSB  = 11;
  localparam int RDEST_LSB  = 8;
  localparam int EXT_MSB    = 7;
  localparam int EXT_LSB    = 4;
  localparam int RSRC_MSB   = 3;
  localparam int RSRC_LSB   = 0;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rdest;
    logic [3:0] ext;
    logic [3:0] rsrc;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input word_t w);
    return instr_fields_t'(w);
  endfunction

  function automatic logic is_halt(input word_t w);
    return (w == HALT_WORD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_if
// Description : Fetch-unit bus bundle.
//               Memory side : mem_rd_en, mem_addr (out), mem_rdata (in)
//               Decoder side: instr, instr_pc, instr_valid (out), instr_ready (in)
//               Control     : redirect, redirect_pc (in), halted (out)
//               master = fetch unit, slave = memory/decoder/control side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 16
);
  import proc_pkg::*;

  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  word_t                 mem_rdata;
  word_t                 instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  halted;

  modport master (
    output mem_rd_en, mem_addr, instr, instr_pc, instr_valid, halted,
    input  mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_rd_en, mem_addr, instr, instr_pc, instr_valid, halted,
    output mem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch buffer of {word, pc} entries. Synchronous FIFO with
//               push/pop, synchronous flush and occupancy count.
//               Ports: clk, rst (async, active-high), i_flush, i_push,
//               i_push_word, i_push_pc, i_pop, o_head_word, o_head_pc, o_count.
//               Head outputs read 0 when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int PC_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  word_t                        i_push_word,
  input  logic [PC_WIDTH-1:0]          i_push_pc,
  input  logic                         i_pop,
  output word_t                        o_head_word,
  output logic [PC_WIDTH-1:0]          o_head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);

  word_t               r_word_mem [DEPTH];
  logic [PC_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_cnt_w'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  // When full, a simultaneous pop frees the slot the push lands in
  // (wr_ptr == rd_ptr), so the write lands safely behind the new head.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (!i_flush && w_do_push) begin
      r_word_mem[r_wr_ptr] <= i_push_word;
      r_pc_mem[r_wr_ptr]   <= i_push_pc;
    end
  end

  assign o_head_word = w_empty ? '0 : r_word_mem[r_rd_ptr];
  assign o_head_pc   = w_empty ? '0 : r_pc_mem[r_rd_ptr];
  assign o_count     = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && w_full && !w_do_pop));

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit. Owns the PC, issues reads to a
//               synchronous instruction memory (data one cycle after the
//               strobe), buffers returned words in fetch_fifo and presents
//               them to the decoder over valid/ready. Supports PC redirect
//               and stops for good once the end-of-program word is accepted.
//               Ports: clk, rst (async, active-high), bus (instr_fetch_if
//               master: memory read port, decoder handshake, redirect, halted).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
  import proc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_if.master      bus
);

  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam int c_occ_w = c_cnt_w + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_issue_pc;
  logic                  r_inflight;
  logic                  r_halted;

  logic [c_cnt_w-1:0]    w_count;
  word_t                 w_head_word;
  logic [ADDR_WIDTH-1:0] w_head_pc;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_halt_pop;
  logic                  w_flush;
  logic                  w_push;
  logic                  w_issue;
  logic [c_occ_w-1:0]    w_occ;

  assign w_valid    = (w_count != '0) && !r_halted;
  assign w_pop      = w_valid && bus.instr_ready;
  assign w_halt_pop = w_pop && is_halt(w_head_word);

  // Redirect is ignored once halted, and loses to a halt in the same cycle.
  assign w_flush    = bus.redirect && !r_halted && !w_halt_pop;

  // Occupancy including the outstanding read, net of this cycle's pop;
  // issuing only below DEPTH is what makes buffer overflow impossible.
  assign w_occ      = c_occ_w'(w_count) + c_occ_w'(r_inflight) - c_occ_w'(w_pop);
  assign w_issue    = !rst && !r_halted && !bus.redirect && (w_occ < c_occ_w'(DEPTH));

  // A response landing in a redirect cycle belongs to the old stream.
  assign w_push     = r_inflight && !w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_issue_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc       <= r_pc + ADDR_WIDTH'(1);
        r_issue_pc <= r_pc;
      end else if (w_flush) begin
        r_pc <= bus.redirect_pc;
      end
      if (w_halt_pop) r_halted <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (ADDR_WIDTH)
  ) u_fetch_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_word (bus.mem_rdata),
    .i_push_pc   (r_issue_pc),
    .i_pop       (w_pop),
    .o_head_word (w_head_word),
    .o_head_pc   (w_head_pc),
    .o_count     (w_count)
  );

  assign bus.mem_rd_en   = w_issue;
  assign bus.mem_addr    = r_pc;
  assign bus.instr       = w_head_word;
  assign bus.instr_pc    = w_head_pc;
  assign bus.instr_valid = w_valid;
  assign bus.halted      = r_halted;

endmodule
`default_nettype wire
